// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx_if
// Description : Bundle of the serial line and the byte/flag outputs of the
//               serial frame receiver.
//               master : drives rx_in, observes the received byte and flags
//               slave  : the receiver (samples rx_in, drives the results)
// Signals     : rx_in       serial line, idles high
//               data_out    received byte, first data bit in bit 7
//               data_valid  one-cycle strobe for data_out and flags
//               parity_err  received parity disagreed with the data
//               frame_err   stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err
    );

    modport slave (
        input  rx_in,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : Receiver for 11-bit serial frames (start 0, 8 data bits MSB
//               first, even parity bit, stop 1). Recovers the byte and
//               reports it with a one-cycle strobe plus parity/framing flags.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    serial_frame_rx_if.slave (rx_in in; data_out,
//                      data_valid, parity_err, frame_err out, all registered)
// Parameters  : CLKS_PER_BIT  clk cycles per serial bit (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_frame_rx_if.slave   bus
);

    // Offset into the start bit at which it is confirmed (not overridable).
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             perr_q;
    logic             ferr_q;

    logic rx_s;
    logic bit_tick;

    assign rx_s     = sync_q[1];
    // Sample point of every bit after the start bit: last cycle of the bit
    // period, counted from the mid-start confirmation point.
    assign bit_tick = (clk_cnt_q == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 2'b11;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx_in};
            valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        bit_cnt_q <= '0;
                        // With one or two clocks per bit there is no room
                        // for a mid-bit check; the low level is the start bit.
                        if (HALF_BIT == 0) begin
                            state_q   <= S_DATA;
                            clk_cnt_q <= '0;
                        end else begin
                            state_q   <= S_START;
                            clk_cnt_q <= C_CNT_ONE;
                        end
                    end
                end

                S_START: begin
                    if (clk_cnt_q == C_CNT_HALF) begin
                        clk_cnt_q <= '0;
                        // A line back high by mid-start was a glitch.
                        state_q   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (bit_tick) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {shift_q[6:0], rx_s};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= S_PARITY;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
                    end
                end

                S_PARITY: begin
                    if (bit_tick) begin
                        clk_cnt_q <= '0;
                        par_q     <= rx_s;
                        state_q   <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (bit_tick) begin
                        clk_cnt_q <= '0;
                        data_q    <= shift_q;
                        perr_q    <= (^shift_q) ^ par_q;
                        ferr_q    <= ~rx_s;
                        valid_q   <= 1'b1;
                        // A low stop bit may be the start of a break; wait
                        // for the line to return high before hunting again.
                        state_q   <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Self-checking bench for serial_frame_rx. One receiver runs at
//               one clock per bit, a second at sixteen. Frames are built from
//               the frame rules, expected results queued per receiver and
//               matched against every data_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;   // expected strobe cycle, -1 when not checked
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    exp_t q1[$];
    exp_t q16[$];
    exp_t e1;
    exp_t e16;

    serial_frame_rx_if if1 ();
    serial_frame_rx_if if16 ();

    serial_frame_rx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    serial_frame_rx #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 1) if1.rx_in = v;
        else            if16.rx_in = v;
    endtask

    // Hold the line at lvl for nbits bit periods.
    task automatic idle(input int which, input int nbits, input logic lvl);
        int cpb;
        cpb = (which == 1) ? 1 : 16;
        repeat (nbits * cpb) begin
            @(negedge clk);
            set_line(which, lvl);
        end
    endtask

    // Send one frame; the parity bit is the even parity of d, inverted when
    // flip is set. Queues what the receiver must report for it.
    task automatic send_frame(input int which, input logic [7:0] d,
                              input logic flip, input logic stopb);
        logic [10:0] bits;
        logic        pbit;
        int          cpb;
        exp_t        e;
        cpb  = (which == 1) ? 1 : 16;
        pbit = (^d) ^ flip;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[7 - i];
        bits[9]  = pbit;
        bits[10] = stopb;
        e.d  = d;
        e.pe = ((^d) != pbit);
        e.fe = (stopb == 1'b0);
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            if (b == 0) begin
                // Start bit is sampled on the next edge; the strobe must be
                // visible 12 edges after that.
                e.cyc = (which == 1) ? (cyc + 13) : -1;
                if (which == 1) q1.push_back(e);
                else            q16.push_back(e);
            end
            set_line(which, bits[b]);
            repeat (cpb - 1) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if1.data_valid === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_data", {24'd0, if1.data_out}, {24'd0, e1.d});
                chk("dut1_parity_err", {31'd0, if1.parity_err}, {31'd0, e1.pe});
                chk("dut1_frame_err", {31'd0, if1.frame_err}, {31'd0, e1.fe});
                if (e1.cyc >= 0) chk("dut1_latency", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if16.data_valid === 1'b1) begin
            if (q16.size() == 0) begin
                chk("dut16_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                chk("dut16_data", {24'd0, if16.data_out}, {24'd0, e16.d});
                chk("dut16_parity_err", {31'd0, if16.parity_err}, {31'd0, e16.pe});
                chk("dut16_frame_err", {31'd0, if16.frame_err}, {31'd0, e16.fe});
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       flip;
        logic       st;
        logic [7:0] pd;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if1.rx_in  = 1'b1;
        if16.rx_in = 1'b1;

        // Reset state
        #1;
        chk("rst_data1", {24'd0, if1.data_out}, 32'd0);
        chk("rst_valid1", {31'd0, if1.data_valid}, 32'd0);
        chk("rst_perr1", {31'd0, if1.parity_err}, 32'd0);
        chk("rst_ferr1", {31'd0, if1.frame_err}, 32'd0);
        chk("rst_data16", {24'd0, if16.data_out}, 32'd0);
        chk("rst_valid16", {31'd0, if16.data_valid}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1, 3, 1'b1);

        // Single frame 0xA5, then check outputs are held after the strobe
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        idle(1, 6, 1'b1);
        chk("hold_data", {24'd0, if1.data_out}, 32'hA5);
        chk("hold_valid_low", {31'd0, if1.data_valid}, 32'd0);

        // Parity error
        send_frame(1, 8'hA5, 1'b1, 1'b1);
        idle(1, 4, 1'b1);
        chk("hold_perr", {31'd0, if1.parity_err}, 32'd1);

        // Frame error, long low hold (break), then a good frame
        send_frame(1, 8'h3C, 1'b0, 1'b0);
        idle(1, 20, 1'b0);
        idle(1, 1, 1'b1);
        send_frame(1, 8'h81, 1'b0, 1'b1);
        idle(1, 3, 1'b1);

        // Back-to-back with no gap
        send_frame(1, 8'h00, 1'b0, 1'b1);
        send_frame(1, 8'hFF, 1'b0, 1'b1);
        idle(1, 4, 1'b1);

        // Glitch rejection at 16 clocks per bit, then a full frame
        idle(16, 1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if16.rx_in = 1'b0;
        end
        idle(16, 3, 1'b1);
        send_frame(16, 8'h5A, 1'b0, 1'b1);
        idle(16, 2, 1'b1);

        // Reset in the middle of a frame; outputs hold 0xC3 with both flags
        send_frame(1, 8'hC3, 1'b1, 1'b0);
        idle(1, 3, 1'b0);
        idle(1, 2, 1'b1);
        pd = 8'h96;
        @(negedge clk); if1.rx_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); if1.rx_in = pd[7 - i];
        end
        @(negedge clk); if1.rx_in = pd[3];
        #2;
        rst_n = 1'b0;
        if1.rx_in = 1'b1;
        #1;
        chk("midrst_data", {24'd0, if1.data_out}, 32'd0);
        chk("midrst_valid", {31'd0, if1.data_valid}, 32'd0);
        chk("midrst_perr", {31'd0, if1.parity_err}, 32'd0);
        chk("midrst_ferr", {31'd0, if1.frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1, 20, 1'b1);
        send_frame(1, 8'h6E, 1'b0, 1'b1);
        idle(1, 3, 1'b1);

        // Randomized frames, one clock per bit
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            st   = ($urandom_range(0, 4) != 0);
            send_frame(1, d, flip, st);
            if (!st) begin
                idle(1, $urandom_range(0, 5), 1'b0);
                idle(1, $urandom_range(1, 2), 1'b1);
            end else begin
                idle(1, $urandom_range(0, 2), 1'b1);
            end
        end

        // Randomized frames, sixteen clocks per bit
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 2) == 0);
            st   = ($urandom_range(0, 3) != 0);
            send_frame(16, d, flip, st);
            if (!st) begin
                idle(16, $urandom_range(0, 2), 1'b0);
                idle(16, 1, 1'b1);
            end else begin
                idle(16, $urandom_range(0, 1), 1'b1);
            end
        end

        // Bounded drain: every queued frame must have produced its strobe
        idle(16, 14, 1'b1);
        chk("dut1_missing_strobes", q1.size(), 32'd0);
        chk("dut16_missing_strobes", q16.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receives the 11-bit serial frames produced by the team's serial transmitter FSM and recovers the data byte.
- Frame format: start bit (0), 8 data bits MSB first, parity bit, stop bit (1).
- Parity bit = XOR of the 8 data bits (even parity).
- Sits directly downstream of the transmitter's tx_out line. Presents each byte with a one-cycle valid strobe and per-frame error flags.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit. Must be ≥1. The value 1 matches the transmitter's one-bit-per-clock output.
- HALF_BIT, (CLKS_PER_BIT-1)/2, derived, not overridable. Sample offset used to confirm the start bit.

Ports:
- clk  input  1  rising-edge clock, shared with transmitter
- rst_n  input  1  asynchronous active-low reset
- rx_in  input  1  serial line, idles high
- data_out  output  8  received byte; first data bit received lands in data_out[7]
- data_valid  output  1  one-cycle pulse: new byte and flags are valid
- parity_err  output  1  XOR of received data bits != received parity bit; updated with data_valid, then held
- frame_err  output  1  stop bit sampled 0; updated with data_valid, then held

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, counters 0.
  - 2-flop input synchroniser preset to 1.
  - data_out=8'h00, data_valid=0, parity_err=0, frame_err=0.
  - Reset mid-frame discards the partial frame and produces no data_valid.
- rx_s is rx_in after the 2-flop synchroniser. All decisions use rx_s.
- bit_cnt counts 0..8 received data bits. clk_cnt counts 0..CLKS_PER_BIT-1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rx_s=0 with HALF_BIT=0: go to DATA, clk_cnt=0, bit_cnt=0.
  - rx_s=0 with HALF_BIT>0: go to START, clk_cnt=1.
- START:
  - clk_cnt increments each cycle.
  - At clk_cnt==HALF_BIT: rx_s=0 goes to DATA with clk_cnt=0. rx_s=1 is a glitch and returns to IDLE with no output.
- DATA:
  - Sample rx_s when clk_cnt==CLKS_PER_BIT-1, then reset clk_cnt; otherwise increment.
  - Each sample shifts into an 8-bit shift register (left shift, new bit at LSB).
  - After the 8th sample, go to PARITY.
- PARITY: one sample with the same timing, stored. Then go to STOP.
- STOP: one sample with the same timing. On the sampling edge:
  - data_out <= shift register.
  - parity_err <= (^shift register) ^ parity sample.
  - frame_err <= ~stop sample.
  - data_valid <= 1 for exactly one cycle.
  - Next state: IDLE if stop sample=1, BREAK if stop sample=0.
- BREAK: stay until rx_s=1, then go to IDLE. No start detection while in BREAK.
- data_valid is asserted even when an error flag is set. The consumer decides whether to discard the byte.
- Back-to-back frames need no idle gap. IDLE can detect a new start bit on the cycle after the stop sample.
- Latency (CLKS_PER_BIT=1): data_valid is high after the 12th rising edge following the edge where rx_in is first sampled low.
- Outputs are registered; there is no combinational path from rx_in.

Test Plan:
- Single frame, CLKS_PER_BIT=1:
  - Stimulus: rx_in = 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0).
  - Required: data_out=8'hA5, data_valid for exactly 1 cycle, 12 edges after start, parity_err=0, frame_err=0.
- Parity error:
  - Stimulus: same frame with parity bit 1.
  - Required: data_out=8'hA5, data_valid=1, parity_err=1, frame_err=0.
- Frame error and break:
  - Stimulus: 0x3C frame with stop=0, line then held 0 for 20 cycles, then 1, then a 0x81 frame.
  - Required: first data_valid with frame_err=1 and data_out=8'h3C; no strobe during the low hold; second strobe with data_out=8'h81, frame_err=0.
- Back-to-back, zero gap:
  - Stimulus: frames 0x00 then 0xFF contiguous.
  - Required: two strobes exactly 11 cycles apart; values 8'h00 then 8'hFF; both error flags 0.
- Glitch rejection, CLKS_PER_BIT=16:
  - Stimulus: rx_in low for 3 cycles, then high.
  - Required: return to IDLE, no data_valid. A subsequent full 0x5A frame at 16 clk/bit yields data_out=8'h5A.
- Reset mid-frame:
  - Stimulus: rst_n low during data bit 4 of a frame, released on an idle-high line.
  - Required: all outputs 0 immediately (async), no strobe for the aborted frame. The next full frame is received correctly.
